// File: rtl/init_check.sv
// Post-init checker: sweeps the S memory and compares each word against addr ^ XOR_MASK.
// Optional INIT_CHECK_STREAM_EN macro adds a rd_valid/rd_byte stream of every returned word.
module init_check #(
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] XOR_MASK = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic              rden,
    output logic              wren,
    input  logic [DATA_W-1:0] rddata,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
`ifdef INIT_CHECK_STREAM_EN
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_byte,
`endif
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter is one bit wider than addr so DEPTH == 2**ADDR_W terminates cleanly.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] MAX_ERR   = (ADDR_W + 1)'(DEPTH);

    function automatic logic [DATA_W-1:0] expected_word(input logic [ADDR_W:0] a);
        logic [DATA_W-1:0] w;
        w = DATA_W'(a);
        return w ^ XOR_MASK;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     cmp_addr_q, cmp_addr_d;
    logic                vld_q, vld_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                seen_q, seen_d;
    logic                pass_q, pass_d;
    logic                rdy_q, rden_q, done_q;

    // Next-state, compare and result-update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmp_addr_d = cmp_addr_q;
        vld_d      = 1'b0;
        err_d      = err_q;
        first_d    = first_q;
        seen_d     = seen_q;
        pass_d     = pass_q;

        if (vld_q && (rddata != expected_word(cmp_addr_q))) begin
            if (err_q != MAX_ERR) begin
                err_d = err_q + (ADDR_W + 1)'(1);
            end else begin
                err_d = err_q;
            end
            if (!seen_q) begin
                first_d = cmp_addr_q[ADDR_W-1:0];
                seen_d  = 1'b1;
            end else begin
                first_d = first_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_READ;
                    cnt_d   = {(ADDR_W + 1){1'b0}};
                    err_d   = {(ADDR_W + 1){1'b0}};
                    first_d = {ADDR_W{1'b0}};
                    seen_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                vld_d      = 1'b1;
                cmp_addr_d = cnt_q;
                cnt_d      = cnt_q + (ADDR_W + 1)'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                // err_d already includes the final word, so pass is valid alongside done.
                state_d = S_DONE;
                pass_d  = (err_d == {(ADDR_W + 1){1'b0}});
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pipeline, result and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {(ADDR_W + 1){1'b0}};
            cmp_addr_q <= {(ADDR_W + 1){1'b0}};
            vld_q      <= 1'b0;
            err_q      <= {(ADDR_W + 1){1'b0}};
            first_q    <= {ADDR_W{1'b0}};
            seen_q     <= 1'b0;
            pass_q     <= 1'b0;
            rdy_q      <= 1'b1;
            rden_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmp_addr_q <= cmp_addr_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            first_q    <= first_d;
            seen_q     <= seen_d;
            pass_q     <= pass_d;
            rdy_q      <= (state_d == S_IDLE);
            rden_q     <= (state_d == S_READ);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign rdy            = rdy_q;
    assign rden           = rden_q;
    assign done           = done_q;
    assign addr           = cnt_q[ADDR_W-1:0];
    assign wren           = 1'b0;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

`ifdef INIT_CHECK_STREAM_EN
    assign rd_valid = vld_q;
    assign rd_byte  = rddata;
`endif

endmodule
